// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one registered shift datapath between two requesters.
// Optional rotate-left for dir=0/type=1 is enabled by defining SHIFT_ROTATE_EN.
module shift_arbiter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [WIDTH-1:0]   req_a0,
  input  logic [SHAMT_W-1:0] req_shamt0,
  input  logic               req_dir0,
  input  logic               req_type0,
  input  logic [WIDTH-1:0]   req_a1,
  input  logic [SHAMT_W-1:0] req_shamt1,
  input  logic               req_dir1,
  input  logic               req_type1,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               grant_id,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_n;

  logic               ptr;
  logic               win;
  logic               accept;
  logic               hs;
  logic [WIDTH-1:0]   a_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic               dir_q;
  logic               type_q;
  logic [WIDTH-1:0]   shift_res;

  assign busy = (state != IDLE);

  // State register; reset abandons any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state, arbitration and handshake outputs
  always_comb begin
    state_n   = state;
    req_ready = '0;
    rsp_valid = '0;
    win       = 1'b0;
    accept    = 1'b0;
    hs        = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid == 2'b10 || (req_valid == 2'b11 && ptr))
          win = 1'b1;
        if (|req_valid && !rst) begin
          accept         = 1'b1;
          req_ready[win] = 1'b1;
          state_n        = EXEC;
        end
      end
      EXEC: state_n = RESP;
      RESP: begin
        rsp_valid[grant_id] = 1'b1;
        if (rsp_ready[grant_id]) begin
          hs      = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef SHIFT_ROTATE_EN
  logic [2*WIDTH-1:0] dbl;
  assign dbl = {a_q, a_q} << shamt_q;
`endif

  // Shift result from the latched operands
  always_comb begin
    shift_res = a_q << shamt_q;
    if (dir_q) begin
      if (type_q) shift_res = $unsigned($signed(a_q) >>> shamt_q);
      else        shift_res = a_q >> shamt_q;
    end else if (type_q) begin
`ifdef SHIFT_ROTATE_EN
      shift_res = dbl[2*WIDTH-1:WIDTH];
`else
      shift_res = a_q << shamt_q;
`endif
    end
  end

  // Operand latch, grant/pointer update, result and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 1'b0;
      grant_id <= 1'b0;
      a_q      <= '0;
      shamt_q  <= '0;
      dir_q    <= 1'b0;
      type_q   <= 1'b0;
      rsp_data <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        grant_id <= win;
        ptr      <= ~win;
        a_q      <= win ? req_a1 : req_a0;
        shamt_q  <= win ? req_shamt1 : req_shamt0;
        dir_q    <= win ? req_dir1 : req_dir0;
        type_q   <= win ? req_type1 : req_type0;
      end
      if (state == EXEC)
        rsp_data <= shift_res;
      if (hs)
        op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit shift datapath between two requesters: port 0 (ALU issue) and port 1 (address/immediate unit).
- Round-robin arbitration; operands are latched on grant and the result is registered.
- Each requester sees a valid/ready request and a valid/ready response.
- Sits between the decode/issue stage and the shift datapath; it is the only driver of that datapath.

Parameters:
- WIDTH, 32, data width of operand and result.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit i = requester i.
- req_ready  output  2  per-requester accept; at most one bit high.
- req_a0  input  WIDTH  requester 0 operand.
- req_shamt0  input  SHAMT_W  requester 0 shift amount.
- req_dir0  input  1  requester 0 direction: 0 = left, 1 = right.
- req_type0  input  1  requester 0 type: 0 = logical, 1 = arithmetic.
- req_a1, req_shamt1, req_dir1, req_type1  input  as above  requester 1 fields.
- rsp_valid  output  2  per-requester result valid; at most one bit high.
- rsp_ready  input  2  per-requester result accept.
- rsp_data  output  WIDTH  registered shift result, shared by both requesters.
- grant_id  output  1  index of the requester currently owning the unit.
- busy  output  1  high in any state except IDLE.
- op_count  output  CNT_W  number of completed responses.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_data=0; grant_id=0; busy=0; op_count=0.
  - Round-robin pointer = 0, so requester 0 has priority first.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational. Only one requester valid: that one wins. Both valid: the pointer's index wins.
  - The winner's req_ready bit is high in the same cycle; the other bit stays 0. None valid: req_ready=0.
  - On req_valid & req_ready at a rising edge: latch a, shamt, dir, type; set grant_id to the winner; toggle the pointer to the non-winner; go to EXEC.
- EXEC (one cycle): compute the shift on the latched operands and register it into rsp_data; go to RESP.
  - dir=0, type=0: logical left. Zero-fill from bit 0.
  - dir=1, type=0: logical right. Zero-fill from the MSB.
  - dir=1, type=1: arithmetic right. Fill with the operand MSB (signed).
  - dir=0, type=1: logical left, unless SHIFT_ROTATE_EN is defined.
  - shamt=0 returns the operand unchanged.
  - Only the low SHAMT_W bits of shamt are used; there is no overflow case.
- RESP:
  - rsp_valid[grant_id]=1 and is held, with rsp_data stable, until rsp_ready[grant_id]=1 at a rising edge.
  - On that edge: op_count increments, wrapping from 2**CNT_W-1 to 0; go to IDLE.
  - rsp_ready of the non-owner is ignored.
- Latency and throughput:
  - Accept edge T, then rsp_valid high from T+2 (after the edge two cycles later).
  - Minimum 3 cycles per operation; no accept happens in the same cycle as a response handshake.
- Requests in non-IDLE states: req_ready=0 and requests are not dropped. A requester must hold req_valid and its fields until accepted.
- Changes to operand inputs after the accept edge have no effect on the result.
- Reset asserted during EXEC or RESP:
  - The in-flight operation is abandoned and no response is produced.
  - op_count does not increment.
  - Pointer returns to 0.

Optional Feature:
- Macro: SHIFT_ROTATE_EN.
- Defined: dir=0, type=1 performs rotate left by shamt; bits shifted out of the MSB re-enter at bit 0. Example: 32'h8000_0001 rotated left by 1 = 32'h0000_0003.
- Undefined: dir=0, type=1 is identical to logical left, and no rotate logic is synthesised.

Test Plan:
- Single request: req0 a=32'h0000_00F0, shamt=4, dir=0, type=0 -> rsp_valid[0] two cycles after accept; rsp_data=32'h0000_0F00; op_count=1.
- Arithmetic right: req1 a=32'hF000_0000, shamt=8, dir=1, type=1 -> rsp_data=32'hFFF0_0000. Same operand with type=0 -> rsp_data=32'h00F0_0000.
- Simultaneous requests from reset:
  - Both valid -> req0 granted first and req1 second; grant_id sequence 0,1.
  - Both then held valid -> grants alternate 0,1,0,1.
  - req1 never waits more than one operation.
- Response backpressure: hold rsp_ready[0]=0 for 5 cycles in RESP -> rsp_valid[0] and rsp_data stable; req_ready=0 throughout; on release, IDLE next cycle.
- Reset mid-operation: assert rst during EXEC -> all outputs return to reset values immediately; no rsp_valid; op_count unchanged (0).
- Edge cases:
  - shamt=0 on a=32'hDEAD_BEEF -> rsp_data=32'hDEAD_BEEF.
  - dir=0, type=1 on a=32'h8000_0001, shamt=1 -> 32'h0000_0002 without SHIFT_ROTATE_EN; 32'h0000_0003 with it.
